// File: rtl/mul_unit_pkg.sv
// Shared types and op-decode helpers for the pipelined multiply unit.
package mul_unit_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    // Returns {a_signed, b_signed}; MUL's low half does not depend on it.
    function automatic logic [1:0] op_signs(mul_op_e op);
        logic [1:0] s;
        s = 2'b11;
        case (op)
            MUL_OP_MUL:    s = 2'b11;
            MUL_OP_MULH:   s = 2'b11;
            MUL_OP_MULHSU: s = 2'b10;
            MUL_OP_MULHU:  s = 2'b00;
            default:       s = 2'b11;
        endcase
        return s;
    endfunction

    function automatic logic op_high(mul_op_e op);
        return op != MUL_OP_MUL;
    endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Upstream issue and downstream result handshakes of mul_unit, bundled as one interface.
interface mul_unit_if
    import mul_unit_pkg::*;
#(
    parameter int p_width = 4
);
    logic               valid_i;
    logic               ready_o;
    logic [p_width-1:0] a_i;
    logic [p_width-1:0] b_i;
    mul_op_e            op_i;
    logic               valid_o;
    logic               ready_i;
    logic [p_width-1:0] result_o;

    modport slave (
        input  valid_i, a_i, b_i, op_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output valid_i, a_i, b_i, op_i, ready_i,
        input  ready_o, valid_o, result_o
    );
endinterface

// File: rtl/mul_unit_multiply.sv
// Combinational multiply core: per-operand signedness, full 2*p_width-bit product.
module multiply #(
    parameter int p_width = 4
) (
    input  logic [p_width-1:0]   a,
    input  logic [p_width-1:0]   b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic [2*p_width-1:0] product
);
    logic signed [2*p_width-1:0] a_ext;
    logic signed [2*p_width-1:0] b_ext;

    // Extending both operands to the product width makes the truncated product exact.
    assign a_ext   = {{p_width{a_signed & a[p_width-1]}}, a};
    assign b_ext   = {{p_width{b_signed & b[p_width-1]}}, b};
    assign product = a_ext * b_ext;
endmodule

// File: rtl/mul_unit.sv
// Two-stage handshaked multiply unit (operand register, result register).
// Optional MUL_UNIT_SKID_EN adds a 2-entry skid buffer after S2 and a registered ready_o.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int p_width = 4
) (
    input  logic     clk_i,
    input  logic     reset_i,
    mul_unit_if.slave bus
);
    logic               vld_p1;
    logic [p_width-1:0] a_p1;
    logic [p_width-1:0] b_p1;
    mul_op_e            op_p1;
    logic [1:0]         signs_p1;
    logic [2*p_width-1:0] product_p1;
    logic [p_width-1:0] sel_p1;
    logic               vld_p2;
    logic [p_width-1:0] result_p2;
    logic               in_fire;
    logic               s1_load;
    logic               s2_adv;
    logic               s2_go;

    assign in_fire  = bus.valid_i & bus.ready_o;
    assign s2_adv   = vld_p1 & (~vld_p2 | s2_go);
    assign s1_load  = ~vld_p1 | s2_adv;
    assign signs_p1 = op_signs(op_p1);
    assign sel_p1   = op_high(op_p1) ? product_p1[2*p_width-1:p_width] : product_p1[p_width-1:0];

    multiply #(.p_width(p_width)) u_multiply (
        .a        (a_p1),
        .b        (b_p1),
        .a_signed (signs_p1[1]),
        .b_signed (signs_p1[0]),
        .product  (product_p1)
    );

    // S1: operand register
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            a_p1  <= bus.a_i;
            b_p1  <= bus.b_i;
            op_p1 <= bus.op_i;
        end
    end

    // S2: selected result register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            result_p2 <= '0;
        end else begin
            if (s1_load) vld_p1 <= in_fire;
            if (s2_adv) begin
                vld_p2    <= 1'b1;
                result_p2 <= sel_p1;
            end else if (s2_go) begin
                vld_p2 <= 1'b0;
            end
        end
    end

`ifdef MUL_UNIT_SKID_EN
    logic [1:0]         skid_cnt;
    logic [p_width-1:0] skid0;
    logic [p_width-1:0] skid1;
    logic               ready_q;
    logic               pop;
    logic               push;
    logic               deliver;
    logic [2:0]         occ;
    logic [2:0]         occ_next;

    // S2 empties either straight to the consumer (buffer empty) or into the buffer.
    assign s2_go    = vld_p2 & ((skid_cnt != 2'd2) | bus.ready_i);
    assign pop      = (skid_cnt != 2'd0) & bus.ready_i;
    assign push     = s2_go & ~((skid_cnt == 2'd0) & bus.ready_i);
    assign bus.valid_o  = vld_p2 | (skid_cnt != 2'd0);
    assign bus.result_o = (skid_cnt != 2'd0) ? skid0 : result_p2;
    assign bus.ready_o  = ready_q & ~reset_i;
    assign deliver  = bus.valid_o & bus.ready_i;
    assign occ      = {2'b00, vld_p1} + {2'b00, vld_p2} + {1'b0, skid_cnt};
    assign occ_next = occ + {2'b00, in_fire} - {2'b00, deliver};

    // Skid stage: head in skid0, ready registered from next occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            skid_cnt <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};
            ready_q  <= occ_next < 3'd3;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            skid0 <= skid1;
            if (push) begin
                if (skid_cnt == 2'd1) skid0 <= result_p2;
                else                  skid1 <= result_p2;
            end
        end else if (push) begin
            if (skid_cnt == 2'd0) skid0 <= result_p2;
            else                  skid1 <= result_p2;
        end
    end
`else
    assign s2_go        = vld_p2 & bus.ready_i;
    assign bus.valid_o  = vld_p2;
    assign bus.result_o = result_p2;
    assign bus.ready_o  = ~reset_i & s1_load;
`endif

endmodule

// File: tb/tb_mul_unit.sv
// Randomized self-checking bench for mul_unit against a queue-based arithmetic reference.
module tb_mul_unit;
    import mul_unit_pkg::*;

    logic clk;
    logic reset_i;
    int   n_chk;
    int   n_err;
    int   cyc;
    logic last_in;
    int   last_in_cyc;
    int   last_out_cyc;
    logic [3:0] exp_q[$];

    mul_unit_if #(.p_width(4)) bus ();

    mul_unit #(.p_width(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: interpret each operand by its signedness, multiply as integers, pick a half.
    function automatic logic [3:0] ref_mul(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int av;
        int bv;
        int p;
        logic [7:0] p8;
        av = int'(a);
        bv = int'(b);
        if (op != 2'b11 && a[3]) av = av - 16;
        if (op <= 2'b01 && b[3]) bv = bv - 16;
        p  = av * bv;
        p8 = p[7:0];
        return (op == 2'b00) ? p8[3:0] : p8[7:4];
    endfunction

    task automatic cycle();
        logic in_f;
        logic out_f;
        logic [3:0] r;
        logic [3:0] e;
        int c;
        @(negedge clk);
        in_f  = bus.valid_i && bus.ready_o;
        out_f = bus.valid_o && bus.ready_i;
        r     = bus.result_o;
        e     = ref_mul(bus.op_i, bus.a_i, bus.b_i);
        c     = cyc;
        @(posedge clk);
        #1;
        cyc++;
        last_in = 1'b0;
        if (reset_i) begin
            exp_q.delete();
        end else begin
            if (out_f) begin
                last_out_cyc = c;
                if (exp_q.size() == 0) chk("spurious_result", 32'(r), 32'hDEAD);
                else                   chk("result_order", 32'(r), 32'(exp_q.pop_front()));
            end
            if (in_f) begin
                last_in     = 1'b1;
                last_in_cyc = c;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int g;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || bus.valid_o) && g < 50) begin
            cycle();
            g++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [1:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] exp);
        bus.valid_i = 1'b1;
        bus.op_i    = mul_op_e'(op);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.ready_i = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(bus.ready_o), 32'd1);
        cycle();
        bus.valid_i = 1'b0;
        chk({tag, "_lat1"}, 32'(bus.valid_o), 32'd0);
        cycle();
        chk({tag, "_lat2"}, 32'(bus.valid_o), 32'd1);
        chk(tag, 32'(bus.result_o), 32'(exp));
    endtask

    initial begin
        int idx;
        int guard;
        int accepts;
        int first_in;
        logic pv;
        logic [3:0] pr;
        logic [9:0] iv;

        n_chk = 0; n_err = 0; cyc = 0;
        last_in = 1'b0; last_in_cyc = 0; last_out_cyc = 0;
        reset_i = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.a_i = '0; bus.b_i = '0; bus.op_i = MUL_OP_MUL;

        cycle();
        cycle();
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_result", 32'(bus.result_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd0);
        reset_i = 1'b0;

        directed("mul_3x5",    2'b00, 4'h3, 4'h5, 4'hF);
        directed("mul_fxf",    2'b00, 4'hF, 4'hF, 4'h1);
        directed("mulh_fxf",   2'b01, 4'hF, 4'hF, 4'h0);
        directed("mulh_8x7",   2'b01, 4'h8, 4'h7, 4'hC);
        directed("mulhsu_fxf", 2'b10, 4'hF, 4'hF, 4'hF);
        directed("mulhu_fxf",  2'b11, 4'hF, 4'hF, 4'hE);
        drain();

        // Back-to-back stream with the consumer always ready
        first_in = -1;
        accepts  = 0;
        for (int i = 0; i < 16; i++) begin
            bus.valid_i = 1'b1;
            bus.op_i = mul_op_e'($urandom_range(0, 3));
            bus.a_i  = 4'($urandom);
            bus.b_i  = 4'($urandom);
            #1;
            chk("tput_ready", 32'(bus.ready_o), 32'd1);
            cycle();
            if (last_in) begin
                if (first_in < 0) first_in = last_in_cyc;
                accepts++;
            end
        end
        drain();
        chk("tput_accepts", 32'(accepts), 32'd16);
        chk("tput_span", 32'(last_out_cyc - first_in), 32'd17);

        // Consumer stalled from an empty pipe: count accepts, hold outputs stable
        bus.ready_i = 1'b0;
        accepts = 0;
        pv = 1'b0;
        pr = '0;
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = 1'b1;
            bus.op_i = mul_op_e'($urandom_range(0, 3));
            bus.a_i  = 4'($urandom);
            bus.b_i  = 4'($urandom);
            cycle();
            if (last_in) accepts++;
            if (pv) begin
                chk("stall_valid", 32'(bus.valid_o), 32'd1);
                chk("stall_result", 32'(bus.result_o), 32'(pr));
            end
            pv = bus.valid_o;
            pr = bus.result_o;
        end
`ifdef MUL_UNIT_SKID_EN
        chk("stall_accepts", 32'(accepts), 32'd3);
`else
        chk("stall_accepts", 32'(accepts), 32'd2);
`endif
        chk("stall_ready_low", 32'(bus.ready_o), 32'd0);
        drain();

        // Reset with two ops in flight
        bus.ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.valid_i = 1'b1;
            bus.op_i = MUL_OP_MUL;
            bus.a_i  = 4'(i + 2);
            bus.b_i  = 4'h3;
            cycle();
        end
        bus.valid_i = 1'b0;
        reset_i = 1'b1;
        cycle();
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        chk("flush_result", 32'(bus.result_o), 32'd0);
        reset_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.op_i = MUL_OP_MULHU;
        bus.a_i  = 4'hC;
        bus.b_i  = 4'hB;
        #1;
        chk("post_rst_ready", 32'(bus.ready_o), 32'd1);
        cycle();
        chk("post_rst_accept", 32'(last_in), 32'd1);
        drain();

        // Exhaustive sweep with random handshakes on both sides
        idx = 0;
        guard = 0;
        while (idx < 1024 && guard < 20000) begin
            iv = 10'(idx);
            bus.valid_i = ($urandom_range(0, 9) < 7);
            bus.ready_i = ($urandom_range(0, 9) < 7);
            bus.op_i = mul_op_e'(iv[9:8]);
            bus.a_i  = iv[7:4];
            bus.b_i  = iv[3:0];
            cycle();
            if (last_in) idx++;
            guard++;
        end
        chk("sweep_complete", 32'(idx), 32'd1024);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
